// File: rtl/cgra_router_pkg.sv
// Shared port indices and the broadcast-tree fan-out table for the CGRA mesh router.
package cgra_router_pkg;

    localparam int NUM_PORTS = 5;
    localparam int PTR_W     = 3;

    typedef enum logic [PTR_W-1:0] {
        PORT_L = 3'd0,
        PORT_N = 3'd1,
        PORT_E = 3'd2,
        PORT_S = 3'd3,
        PORT_W = 3'd4
    } port_e;

    // Output set for a broadcast arriving on src, one bit per port index.
    // Horizontal travellers fan out N/S, so every tile is reached exactly once.
    function automatic logic [NUM_PORTS-1:0] mc_mask(input port_e src);
        logic [NUM_PORTS-1:0] m;
        m = '0;
        case (src)
            PORT_L:  m = 5'b11110;
            PORT_W:  m = 5'b01111;
            PORT_E:  m = 5'b11011;
            PORT_N:  m = 5'b01001;
            PORT_S:  m = 5'b00011;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cgra_rr_arbiter.sv
// Five-way round-robin arbiter with a one-hot grant and a registered priority pointer.
// The pointer moves past the winner and holds when nothing is requesting.
module cgra_rr_arbiter
    import cgra_router_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % NUM_PORTS);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = PTR_W'((int'(idx) + 1) % NUM_PORTS);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= PORT_L;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/cgra_router.sv
// Five-port XY mesh router with broadcast tree; one registered flit per output.
// Latency 1 cycle; no backpressure, so a request that loses arbitration is dropped.
module cgra_router
    import cgra_router_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int X_COORD    = 0,
    parameter int Y_COORD    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in_n,
    input  logic [DATA_WIDTH-1:0] data_in_e,
    input  logic [DATA_WIDTH-1:0] data_in_s,
    input  logic [DATA_WIDTH-1:0] data_in_w,
    input  logic [DATA_WIDTH-1:0] data_in_local,
    input  logic [ADDR_WIDTH-1:0] dest_x_n,
    input  logic [ADDR_WIDTH-1:0] dest_x_e,
    input  logic [ADDR_WIDTH-1:0] dest_x_s,
    input  logic [ADDR_WIDTH-1:0] dest_x_w,
    input  logic [ADDR_WIDTH-1:0] dest_x_local,
    input  logic [ADDR_WIDTH-1:0] dest_y_n,
    input  logic [ADDR_WIDTH-1:0] dest_y_e,
    input  logic [ADDR_WIDTH-1:0] dest_y_s,
    input  logic [ADDR_WIDTH-1:0] dest_y_w,
    input  logic [ADDR_WIDTH-1:0] dest_y_local,
    input  logic                  multicast_n,
    input  logic                  multicast_e,
    input  logic                  multicast_s,
    input  logic                  multicast_w,
    input  logic                  multicast_local,
    input  logic                  valid_in_n,
    input  logic                  valid_in_e,
    input  logic                  valid_in_s,
    input  logic                  valid_in_w,
    input  logic                  valid_in_local,
    output logic [DATA_WIDTH-1:0] data_out_n,
    output logic [DATA_WIDTH-1:0] data_out_e,
    output logic [DATA_WIDTH-1:0] data_out_s,
    output logic [DATA_WIDTH-1:0] data_out_w,
    output logic [DATA_WIDTH-1:0] data_out_local,
    output logic [ADDR_WIDTH-1:0] dest_x_out_n,
    output logic [ADDR_WIDTH-1:0] dest_x_out_e,
    output logic [ADDR_WIDTH-1:0] dest_x_out_s,
    output logic [ADDR_WIDTH-1:0] dest_x_out_w,
    output logic [ADDR_WIDTH-1:0] dest_y_out_n,
    output logic [ADDR_WIDTH-1:0] dest_y_out_e,
    output logic [ADDR_WIDTH-1:0] dest_y_out_s,
    output logic [ADDR_WIDTH-1:0] dest_y_out_w,
    output logic                  multicast_out_n,
    output logic                  multicast_out_e,
    output logic                  multicast_out_s,
    output logic                  multicast_out_w,
    output logic                  valid_out_n,
    output logic                  valid_out_e,
    output logic                  valid_out_s,
    output logic                  valid_out_w,
    output logic                  valid_out_local
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] dest_x;
        logic [ADDR_WIDTH-1:0] dest_y;
        logic                  multicast;
    } pkt_t;

    localparam logic [ADDR_WIDTH-1:0] MY_X = ADDR_WIDTH'(X_COORD);
    localparam logic [ADDR_WIDTH-1:0] MY_Y = ADDR_WIDTH'(Y_COORD);

    pkt_t                 in_pkt  [NUM_PORTS];
    logic [NUM_PORTS-1:0] in_vld;
    logic [NUM_PORTS-1:0] route   [NUM_PORTS];
    logic [NUM_PORTS-1:0] out_req [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt     [NUM_PORTS];
    pkt_t                 out_d   [NUM_PORTS];
    pkt_t                 out_q   [NUM_PORTS];
    logic [NUM_PORTS-1:0] vld_d, vld_q;

    assign in_pkt[PORT_L] = '{data_in_local, dest_x_local, dest_y_local, multicast_local};
    assign in_pkt[PORT_N] = '{data_in_n, dest_x_n, dest_y_n, multicast_n};
    assign in_pkt[PORT_E] = '{data_in_e, dest_x_e, dest_y_e, multicast_e};
    assign in_pkt[PORT_S] = '{data_in_s, dest_x_s, dest_y_s, multicast_s};
    assign in_pkt[PORT_W] = '{data_in_w, dest_x_w, dest_y_w, multicast_w};
    assign in_vld = {valid_in_w, valid_in_s, valid_in_e, valid_in_n, valid_in_local};

    // X is resolved fully before Y; equal coordinates deliver to the PE.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            route[i] = '0;
            if (in_pkt[i].multicast)            route[i] = mc_mask(port_e'(i));
            else if (in_pkt[i].dest_x > MY_X)   route[i][PORT_E] = 1'b1;
            else if (in_pkt[i].dest_x < MY_X)   route[i][PORT_W] = 1'b1;
            else if (in_pkt[i].dest_y > MY_Y)   route[i][PORT_S] = 1'b1;
            else if (in_pkt[i].dest_y < MY_Y)   route[i][PORT_N] = 1'b1;
            else                                route[i][PORT_L] = 1'b1;
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_req[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++)
                out_req[o][i] = in_vld[i] & route[i][o];
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        cgra_rr_arbiter u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req_i (out_req[o]),
            .gnt_o (gnt[o])
        );
    end

    // Idle outputs keep their previous payload; only valid drops.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_d[o] = out_q[o];
            vld_d[o] = |gnt[o];
            for (int i = 0; i < NUM_PORTS; i++)
                if (gnt[o][i]) out_d[o] = in_pkt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int o = 0; o < NUM_PORTS; o++) out_q[o] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int o = 0; o < NUM_PORTS; o++) out_q[o] <= out_d[o];
        end
    end

    assign data_out_local  = out_q[PORT_L].data;
    assign valid_out_local = vld_q[PORT_L];

    assign data_out_n      = out_q[PORT_N].data;
    assign dest_x_out_n    = out_q[PORT_N].dest_x;
    assign dest_y_out_n    = out_q[PORT_N].dest_y;
    assign multicast_out_n = out_q[PORT_N].multicast;
    assign valid_out_n     = vld_q[PORT_N];

    assign data_out_e      = out_q[PORT_E].data;
    assign dest_x_out_e    = out_q[PORT_E].dest_x;
    assign dest_y_out_e    = out_q[PORT_E].dest_y;
    assign multicast_out_e = out_q[PORT_E].multicast;
    assign valid_out_e     = vld_q[PORT_E];

    assign data_out_s      = out_q[PORT_S].data;
    assign dest_x_out_s    = out_q[PORT_S].dest_x;
    assign dest_y_out_s    = out_q[PORT_S].dest_y;
    assign multicast_out_s = out_q[PORT_S].multicast;
    assign valid_out_s     = vld_q[PORT_S];

    assign data_out_w      = out_q[PORT_W].data;
    assign dest_x_out_w    = out_q[PORT_W].dest_x;
    assign dest_y_out_w    = out_q[PORT_W].dest_y;
    assign multicast_out_w = out_q[PORT_W].multicast;
    assign valid_out_w     = vld_q[PORT_W];

endmodule

// File: tb/tb_cgra_router.sv
// Directed checks of a cgra_router placed at tile (1,1).
module tb_cgra_router;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] data_in_n, data_in_e, data_in_s, data_in_w, data_in_local;
    logic [3:0]  dest_x_n, dest_x_e, dest_x_s, dest_x_w, dest_x_local;
    logic [3:0]  dest_y_n, dest_y_e, dest_y_s, dest_y_w, dest_y_local;
    logic        multicast_n, multicast_e, multicast_s, multicast_w, multicast_local;
    logic        valid_in_n, valid_in_e, valid_in_s, valid_in_w, valid_in_local;
    logic [15:0] data_out_n, data_out_e, data_out_s, data_out_w, data_out_local;
    logic [3:0]  dest_x_out_n, dest_x_out_e, dest_x_out_s, dest_x_out_w;
    logic [3:0]  dest_y_out_n, dest_y_out_e, dest_y_out_s, dest_y_out_w;
    logic        multicast_out_n, multicast_out_e, multicast_out_s, multicast_out_w;
    logic        valid_out_n, valid_out_e, valid_out_s, valid_out_w, valid_out_local;

    int errors = 0;
    int checks = 0;

    cgra_router #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .X_COORD(1), .Y_COORD(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_in_n(data_in_n), .data_in_e(data_in_e), .data_in_s(data_in_s),
        .data_in_w(data_in_w), .data_in_local(data_in_local),
        .dest_x_n(dest_x_n), .dest_x_e(dest_x_e), .dest_x_s(dest_x_s),
        .dest_x_w(dest_x_w), .dest_x_local(dest_x_local),
        .dest_y_n(dest_y_n), .dest_y_e(dest_y_e), .dest_y_s(dest_y_s),
        .dest_y_w(dest_y_w), .dest_y_local(dest_y_local),
        .multicast_n(multicast_n), .multicast_e(multicast_e), .multicast_s(multicast_s),
        .multicast_w(multicast_w), .multicast_local(multicast_local),
        .valid_in_n(valid_in_n), .valid_in_e(valid_in_e), .valid_in_s(valid_in_s),
        .valid_in_w(valid_in_w), .valid_in_local(valid_in_local),
        .data_out_n(data_out_n), .data_out_e(data_out_e), .data_out_s(data_out_s),
        .data_out_w(data_out_w), .data_out_local(data_out_local),
        .dest_x_out_n(dest_x_out_n), .dest_x_out_e(dest_x_out_e),
        .dest_x_out_s(dest_x_out_s), .dest_x_out_w(dest_x_out_w),
        .dest_y_out_n(dest_y_out_n), .dest_y_out_e(dest_y_out_e),
        .dest_y_out_s(dest_y_out_s), .dest_y_out_w(dest_y_out_w),
        .multicast_out_n(multicast_out_n), .multicast_out_e(multicast_out_e),
        .multicast_out_s(multicast_out_s), .multicast_out_w(multicast_out_w),
        .valid_out_n(valid_out_n), .valid_out_e(valid_out_e), .valid_out_s(valid_out_s),
        .valid_out_w(valid_out_w), .valid_out_local(valid_out_local)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        {valid_in_n, valid_in_e, valid_in_s, valid_in_w, valid_in_local} = '0;
        {multicast_n, multicast_e, multicast_s, multicast_w, multicast_local} = '0;
        {data_in_n, data_in_e, data_in_s, data_in_w, data_in_local} = '0;
        {dest_x_n, dest_x_e, dest_x_s, dest_x_w, dest_x_local} = '0;
        {dest_y_n, dest_y_e, dest_y_s, dest_y_w, dest_y_local} = '0;
    endtask

    // Output valids packed as {local, w, s, e, n}.
    function automatic logic [4:0] vouts();
        return {valid_out_local, valid_out_w, valid_out_s, valid_out_e, valid_out_n};
    endfunction

    // Inputs are driven on the falling edge; results sampled one falling edge later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle();
        #12;
        chk("reset_valids", 32'(vouts()), 32'h0);
        chk("reset_data_e", 32'(data_out_e), 32'h0);
        chk("reset_destx_w", 32'(dest_x_out_w), 32'h0);
        chk("reset_mc_n", 32'(multicast_out_n), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Local unicast to (3,1) goes East.
        valid_in_local = 1; data_in_local = 16'hABCD; dest_x_local = 3; dest_y_local = 1;
        step(); idle();
        chk("l2e_valids", 32'(vouts()), 32'b00010);
        chk("l2e_data", 32'(data_out_e), 32'hABCD);
        chk("l2e_destx", 32'(dest_x_out_e), 32'd3);
        chk("l2e_desty", 32'(dest_y_out_e), 32'd1);

        // North to (1,3) goes South; East output drops valid but holds its payload.
        valid_in_n = 1; data_in_n = 16'h1234; dest_x_n = 1; dest_y_n = 3;
        step(); idle();
        chk("n2s_valids", 32'(vouts()), 32'b00100);
        chk("n2s_data", 32'(data_out_s), 32'h1234);
        chk("e_hold_data", 32'(data_out_e), 32'hABCD);

        // West to (1,1) is delivered locally.
        valid_in_w = 1; data_in_w = 16'h5678; dest_x_w = 1; dest_y_w = 1;
        step(); idle();
        chk("w2l_valids", 32'(vouts()), 32'b10000);
        chk("w2l_data", 32'(data_out_local), 32'h5678);

        // Local broadcast to all four neighbours, not back to the PE.
        valid_in_local = 1; multicast_local = 1; data_in_local = 16'hFFFF;
        dest_x_local = 2; dest_y_local = 2;
        step(); idle();
        chk("lmc_valids", 32'(vouts()), 32'b01111);
        chk("lmc_data", 32'({data_out_n, data_out_e, data_out_s, data_out_w}), 32'hFFFF_FFFF);
        chk("lmc_data_w", 32'(data_out_w), 32'hFFFF);
        chk("lmc_mc", 32'({multicast_out_n, multicast_out_e, multicast_out_s, multicast_out_w}), 32'hF);
        chk("lmc_destx_n", 32'(dest_x_out_n), 32'd2);

        // East to (0,0): X first, so West, not North.
        valid_in_e = 1; data_in_e = 16'h9ABC; dest_x_e = 0; dest_y_e = 0;
        step(); idle();
        chk("e2w_valids", 32'(vouts()), 32'b01000);
        chk("e2w_data", 32'(data_out_w), 32'h9ABC);
        chk("e2w_dest", 32'({dest_x_out_w, dest_y_out_w}), 32'h00);

        // Broadcast arriving from West continues E and fans N, S, Local.
        valid_in_w = 1; multicast_w = 1; data_in_w = 16'h0F0F;
        step(); idle();
        chk("wmc_valids", 32'(vouts()), 32'b10111);
        chk("wmc_data_l", 32'(data_out_local), 32'h0F0F);
        chk("wmc_data_e", 32'(data_out_e), 32'h0F0F);

        // N and S contend for East three cycles running: N, S, N.
        valid_in_n = 1; data_in_n = 16'h1111; dest_x_n = 3; dest_y_n = 1;
        valid_in_s = 1; data_in_s = 16'h2222; dest_x_s = 3; dest_y_s = 1;
        step();
        chk("cont1_valids", 32'(vouts()), 32'b00010);
        chk("cont1_data", 32'(data_out_e), 32'h1111);
        step();
        chk("cont2_valids", 32'(vouts()), 32'b00010);
        chk("cont2_data", 32'(data_out_e), 32'h2222);
        step();
        chk("cont3_data", 32'(data_out_e), 32'h1111);

        // Reset mid-sequence clears outputs without waiting for a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valids", 32'(vouts()), 32'h0);
        chk("rst_data_e", 32'(data_out_e), 32'h0);
        chk("rst_destx_e", 32'(dest_x_out_e), 32'h0);
        chk("rst_data_w", 32'(data_out_w), 32'h0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Pointer back at Local: Local beats North for East.
        valid_in_local = 1; data_in_local = 16'h3333; dest_x_local = 2; dest_y_local = 0;
        valid_in_n = 1; data_in_n = 16'h4444; dest_x_n = 2; dest_y_n = 0;
        step(); idle();
        chk("ptr_rst_data", 32'(data_out_e), 32'h3333);
        step();
        chk("idle_valids", 32'(vouts()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
